// File: rtl/door_motor_driver_if.sv
`timescale 1ns/1ps
`default_nettype none
// ============================================================================
// Module   : door_motor_driver_if
// Brief    : Request, limit and H-bridge bundle between the door FSM and the
//            motor driver stage.
// Revision : 1.0 - initial release
// ============================================================================
interface door_motor_driver_if #(
  parameter int PWM_BITS = 8
) ();
  logic                ena;
  logic                cmd_open;
  logic                cmd_close;
  logic                lim_open;
  logic                lim_closed;
  logic                fault_clr;
  logic                mot_a;
  logic                mot_b;
  logic                fault;
  logic [2:0]          state;
  logic [PWM_BITS:0]   duty;

  modport master (
    output ena, cmd_open, cmd_close, lim_open, lim_closed, fault_clr,
    input  mot_a, mot_b, fault, state, duty
  );

  modport slave (
    input  ena, cmd_open, cmd_close, lim_open, lim_closed, fault_clr,
    output mot_a, mot_b, fault, state, duty
  );
endinterface
`default_nettype wire

// File: rtl/door_motor_driver.sv
`timescale 1ns/1ps
`default_nettype none
// ============================================================================
// Module   : door_motor_driver
// Brief    : H-bridge driver with dead-time, PWM soft-start ramp and travel
//            timeout fault, fed by one-hot open/close requests.
// Revision : 1.0 - initial release
// ============================================================================
module door_motor_driver #(
  parameter int DEAD_CYCLES    = 16,
  parameter int PWM_BITS       = 8,
  parameter int RAMP_DIV       = 64,
  parameter int TIMEOUT_CYCLES = 2000000
) (
  input  logic                 clk,
  input  logic                 rst_n,
  door_motor_driver_if.slave   io_drv
);

  localparam int c_DEAD_W = (DEAD_CYCLES > 1) ? $clog2(DEAD_CYCLES) : 1;
  localparam int c_RAMP_W = (RAMP_DIV > 1) ? $clog2(RAMP_DIV) : 1;
  localparam int c_TO_W   = $clog2(TIMEOUT_CYCLES + 1);

  localparam logic [c_DEAD_W-1:0] c_DEAD_LAST = c_DEAD_W'(DEAD_CYCLES - 1);
  localparam logic [c_RAMP_W-1:0] c_RAMP_LAST = c_RAMP_W'(RAMP_DIV - 1);
  localparam logic [c_TO_W-1:0]   c_TO_LAST   = c_TO_W'(TIMEOUT_CYCLES - 1);
  localparam logic [PWM_BITS:0]   c_DUTY_MAX  = {1'b1, {PWM_BITS{1'b0}}};

  typedef enum logic [2:0] {
    ST_IDLE      = 3'd0,
    ST_DEAD      = 3'd1,
    ST_RUN_OPEN  = 3'd2,
    ST_RUN_CLOSE = 3'd3,
    ST_FAULT     = 3'd4
  } state_t;

  state_t                r_state;
  logic                  r_dir;       // 0 = open, 1 = close
  logic [c_DEAD_W-1:0]   r_dead_cnt;
  logic [PWM_BITS-1:0]   r_pwm_cnt;
  logic [c_RAMP_W-1:0]   r_ramp_cnt;
  logic [PWM_BITS:0]     r_duty;
  logic [c_TO_W-1:0]     r_to_cnt;

  state_t                w_state_nxt;
  logic                  w_dir_nxt;
  logic [c_DEAD_W-1:0]   w_dead_nxt;
  logic [PWM_BITS-1:0]   w_pwm_nxt;
  logic [c_RAMP_W-1:0]   w_ramp_nxt;
  logic [PWM_BITS:0]     w_duty_nxt;
  logic [c_TO_W-1:0]     w_to_nxt;

  logic                  w_req_open;
  logic                  w_req_close;
  logic                  w_req_any;
  logic                  w_dir_req;
  logic                  w_dir_lim;
  logic                  w_opp_req;
  logic                  w_pwm_on;

  // Both requests high is an invalid combination and counts as no request.
  assign w_req_open  = io_drv.cmd_open  & ~io_drv.cmd_close;
  assign w_req_close = io_drv.cmd_close & ~io_drv.cmd_open;
  assign w_req_any   = w_req_open | w_req_close;
  assign w_dir_req   = r_dir ? w_req_close       : w_req_open;
  assign w_dir_lim   = r_dir ? io_drv.lim_closed : io_drv.lim_open;
  assign w_opp_req   = r_dir ? w_req_open        : w_req_close;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state    <= ST_IDLE;
      r_dir      <= 1'b0;
      r_dead_cnt <= '0;
      r_pwm_cnt  <= '0;
      r_ramp_cnt <= '0;
      r_duty     <= '0;
      r_to_cnt   <= '0;
    end else if (io_drv.ena) begin
      r_state    <= w_state_nxt;
      r_dir      <= w_dir_nxt;
      r_dead_cnt <= w_dead_nxt;
      r_pwm_cnt  <= w_pwm_nxt;
      r_ramp_cnt <= w_ramp_nxt;
      r_duty     <= w_duty_nxt;
      r_to_cnt   <= w_to_nxt;
    end
  end

  // Run counters default to zero so every RUN entry starts fresh and duty
  // reads zero whenever the bridge is not being driven.
  always_comb begin
    w_state_nxt = r_state;
    w_dir_nxt   = r_dir;
    w_dead_nxt  = '0;
    w_pwm_nxt   = '0;
    w_ramp_nxt  = '0;
    w_duty_nxt  = '0;
    w_to_nxt    = '0;

    case (r_state)
      ST_IDLE: begin
        if (w_req_open && !io_drv.lim_open) begin
          w_state_nxt = ST_DEAD;
          w_dir_nxt   = 1'b0;
        end else if (w_req_close && !io_drv.lim_closed) begin
          w_state_nxt = ST_DEAD;
          w_dir_nxt   = 1'b1;
        end
      end

      ST_DEAD: begin
        if (!w_req_any) begin
          w_state_nxt = ST_IDLE;
        end else if (w_opp_req) begin
          w_dir_nxt = ~r_dir;
        end else if (r_dead_cnt == c_DEAD_LAST) begin
          if (w_dir_lim) begin
            w_state_nxt = ST_IDLE;
          end else begin
            w_state_nxt = r_dir ? ST_RUN_CLOSE : ST_RUN_OPEN;
          end
        end else begin
          w_dead_nxt = r_dead_cnt + c_DEAD_W'(1);
        end
      end

      ST_RUN_OPEN, ST_RUN_CLOSE: begin
        if (w_dir_lim) begin
          w_state_nxt = ST_IDLE;
        end else if (w_opp_req) begin
          // A reversal always passes through dead-time before driving.
          w_state_nxt = ST_DEAD;
          w_dir_nxt   = ~r_dir;
        end else if (!w_dir_req) begin
          w_state_nxt = ST_IDLE;
        end else if (r_to_cnt == c_TO_LAST) begin
          w_state_nxt = ST_FAULT;
        end else begin
          w_pwm_nxt = r_pwm_cnt + PWM_BITS'(1);
          w_to_nxt  = r_to_cnt + c_TO_W'(1);
          w_duty_nxt = r_duty;
          if (r_ramp_cnt == c_RAMP_LAST) begin
            w_ramp_nxt = '0;
            if (r_duty != c_DUTY_MAX) begin
              w_duty_nxt = r_duty + (PWM_BITS + 1)'(1);
            end
          end else begin
            w_ramp_nxt = r_ramp_cnt + c_RAMP_W'(1);
          end
        end
      end

      ST_FAULT: begin
        if (io_drv.fault_clr && !io_drv.cmd_open && !io_drv.cmd_close) begin
          w_state_nxt = ST_IDLE;
        end
      end

      default: begin
        w_state_nxt = ST_IDLE;
      end
    endcase
  end

  assign w_pwm_on     = ({1'b0, r_pwm_cnt} < r_duty);
  assign io_drv.mot_a = io_drv.ena & (r_state == ST_RUN_OPEN)  & w_pwm_on;
  assign io_drv.mot_b = io_drv.ena & (r_state == ST_RUN_CLOSE) & w_pwm_on;
  assign io_drv.fault = (r_state == ST_FAULT);
  assign io_drv.state = r_state;
  assign io_drv.duty  = r_duty;

endmodule
`default_nettype wire

// File: tb/tb_door_motor_driver.sv
`timescale 1ns/1ps
`default_nettype none
// ============================================================================
// Module   : tb_door_motor_driver
// Brief    : Directed self-checking bench for door_motor_driver.
// Revision : 1.0 - initial release
// ============================================================================
module tb_door_motor_driver;

  logic clk;
  logic rst_n;
  int   n_checks;
  int   n_errors;

  door_motor_driver_if #(.PWM_BITS(3)) dif ();

  door_motor_driver #(
    .DEAD_CYCLES    (4),
    .PWM_BITS       (3),
    .RAMP_DIV       (2),
    .TIMEOUT_CYCLES (100)
  ) u_dut (
    .clk    (clk),
    .rst_n  (rst_n),
    .io_drv (dif.slave)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic tick(input int n);
    for (int i = 0; i < n; i++) begin
      @(posedge clk);
      #1;
    end
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_errors++;
      $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
    end
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: simulation did not complete");
    $fatal(1, "watchdog expired");
  end

  initial begin
    int exp_duty;
    n_checks       = 0;
    n_errors       = 0;
    rst_n          = 1'b0;
    dif.ena        = 1'b1;
    dif.cmd_open   = 1'b0;
    dif.cmd_close  = 1'b0;
    dif.lim_open   = 1'b0;
    dif.lim_closed = 1'b0;
    dif.fault_clr  = 1'b0;
    tick(2);

    chk("reset_state", 32'(dif.state), 0);
    chk("reset_mot_a", 32'(dif.mot_a), 0);
    chk("reset_mot_b", 32'(dif.mot_b), 0);
    chk("reset_fault", 32'(dif.fault), 0);
    chk("reset_duty",  32'(dif.duty),  0);
    rst_n = 1'b1;
    tick(1);

    // Open request: four dead cycles, then soft-start ramp to saturation.
    dif.cmd_open = 1'b1;
    for (int i = 1; i <= 4; i++) begin
      tick(1);
      chk("open_dead_state", 32'(dif.state), 1);
      chk("open_dead_pins",  32'({dif.mot_a, dif.mot_b}), 0);
    end
    tick(1);
    chk("open_run_state", 32'(dif.state), 2);
    chk("open_run_duty0", 32'(dif.duty), 0);
    for (int k = 1; k <= 24; k++) begin
      tick(1);
      exp_duty = (k / 2 > 8) ? 8 : k / 2;
      chk("ramp_duty",  32'(dif.duty), 32'(exp_duty));
      chk("ramp_mot_a", 32'(dif.mot_a), 32'((k % 8) < exp_duty));
      chk("ramp_mot_b", 32'(dif.mot_b), 0);
    end

    // Open limit reached: stop and do not restart while the limit is high.
    dif.lim_open = 1'b1;
    tick(1);
    chk("lim_stop_state", 32'(dif.state), 0);
    chk("lim_stop_mot_a", 32'(dif.mot_a), 0);
    chk("lim_stop_duty",  32'(dif.duty),  0);
    tick(3);
    chk("lim_hold_state", 32'(dif.state), 0);
    dif.lim_open = 1'b0;
    dif.cmd_open = 1'b0;
    tick(1);

    // Reversal from RUN_OPEN to RUN_CLOSE through dead-time.
    dif.cmd_open = 1'b1;
    tick(8);
    chk("rev_run_open", 32'(dif.state), 2);
    dif.cmd_open  = 1'b0;
    dif.cmd_close = 1'b1;
    for (int i = 1; i <= 4; i++) begin
      tick(1);
      chk("rev_dead_state", 32'(dif.state), 1);
      chk("rev_dead_pins",  32'({dif.mot_a, dif.mot_b}), 0);
    end
    tick(1);
    chk("rev_run_close", 32'(dif.state), 3);
    chk("rev_duty0",     32'(dif.duty), 0);

    // Travel timeout: FAULT exactly 100 cycles after RUN entry.
    tick(99);
    chk("to_pre_state", 32'(dif.state), 3);
    chk("to_pre_mot_b", 32'(dif.mot_b), 1);
    chk("to_pre_mot_a", 32'(dif.mot_a), 0);
    tick(1);
    chk("to_fault_state", 32'(dif.state), 4);
    chk("to_fault_flag",  32'(dif.fault), 1);
    chk("to_fault_pins",  32'({dif.mot_a, dif.mot_b}), 0);
    dif.fault_clr = 1'b1;
    tick(1);
    chk("clr_ignored", 32'(dif.state), 4);
    dif.cmd_close = 1'b0;
    tick(1);
    chk("clr_idle_state", 32'(dif.state), 0);
    chk("clr_idle_fault", 32'(dif.fault), 0);
    dif.fault_clr = 1'b0;

    // Both requests high: no start from IDLE, immediate stop from RUN.
    dif.cmd_open  = 1'b1;
    dif.cmd_close = 1'b1;
    tick(2);
    chk("both_idle", 32'(dif.state), 0);
    dif.cmd_close = 1'b0;
    tick(5);
    chk("both_run_entry", 32'(dif.state), 2);
    dif.cmd_close = 1'b1;
    tick(1);
    chk("both_run_stop", 32'(dif.state), 0);
    dif.cmd_close = 1'b0;

    // Enable freeze mid-RUN; duty and timeout resume from held values.
    tick(5);
    chk("ena_run_entry", 32'(dif.state), 2);
    tick(6);
    chk("ena_duty_pre", 32'(dif.duty), 3);
    dif.ena = 1'b0;
    #1;
    chk("ena_pins_low", 32'({dif.mot_a, dif.mot_b}), 0);
    tick(10);
    chk("ena_hold_state", 32'(dif.state), 2);
    chk("ena_hold_duty",  32'(dif.duty), 3);
    chk("ena_hold_pins",  32'({dif.mot_a, dif.mot_b}), 0);
    dif.ena = 1'b1;
    tick(2);
    chk("ena_resume_duty",  32'(dif.duty), 4);
    chk("ena_resume_mot_a", 32'(dif.mot_a), 1);
    tick(91);
    chk("ena_to_pre", 32'(dif.state), 2);
    tick(1);
    chk("ena_to_fault", 32'(dif.state), 4);
    dif.cmd_open  = 1'b0;
    dif.fault_clr = 1'b1;
    tick(1);
    chk("ena_clr_idle", 32'(dif.state), 0);
    dif.fault_clr = 1'b0;

    // Asynchronous reset mid-RUN drops the pins at once.
    dif.cmd_open = 1'b1;
    tick(25);
    chk("rst_pre_mot_a", 32'(dif.mot_a), 1);
    #2;
    rst_n = 1'b0;
    #1;
    chk("rst_async_pins",  32'({dif.mot_a, dif.mot_b}), 0);
    chk("rst_async_state", 32'(dif.state), 0);
    chk("rst_async_duty",  32'(dif.duty), 0);
    dif.cmd_open = 1'b0;
    tick(2);
    rst_n = 1'b1;
    tick(2);
    chk("rst_release_state", 32'(dif.state), 0);

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
`default_nettype wire
